seq_div: RTL and testbench



---
 rtl/seq_div_if.sv | 25 ++
 rtl/seq_div.sv | 138 +++++++++++++
 tb/tb_seq_div.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_if.sv
// seq_div_if: operand/result bundle between the execute-stage control unit
// and the sequential 32/16 divider.
//   start  : one-cycle request pulse from control
//   N, D   : 32-bit dividend, 16-bit divisor (sampled on the accepting edge)
//   Q, R   : 16-bit quotient and remainder (registered)
//   busy   : divider is iterating
//   done   : one-cycle completion pulse
//   dz/ovf : divide-by-zero / quotient-overflow flags of the last operation
// master = control unit side, slave = divider side.
interface seq_div_if;
   logic        start;
   logic [31:0] N;
   logic [15:0] D;
   logic [15:0] Q;
   logic [15:0] R;
   logic        busy;
   logic        done;
   logic        dz;
   logic        ovf;

   modport master (output start, N, D,
                   input  Q, R, busy, done, dz, ovf);
   modport slave  (input  start, N, D,
                   output Q, R, busy, done, dz, ovf);
endinterface

// File: rtl/seq_div.sv
// seq_div: sequential 32/16 unsigned restoring divider.
// One quotient bit per clock, 16 steps per normal operation; divide-by-zero
// and quotient overflow are detected on the accepting edge and complete
// immediately.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_div_if.slave (start/N/D in, Q/R/busy/done/dz/ovf out)
module seq_div (
   input logic       clk,
   input logic       rst_n,
   seq_div_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [16:0] rem_q,   rem_d;
   logic [15:0] sh_q,    sh_d;
   logic [15:0] dreg_q,  dreg_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [15:0] q_q,     q_d;
   logic [15:0] r_q,     r_d;
   logic        busy_q,  busy_d;
   logic        done_q,  done_d;
   logic        dz_q,    dz_d;
   logic        ovf_q,   ovf_d;

   // One restoring step. rem stays below the divisor between steps, so the
   // shifted value fits in 17 bits and bit 17 of the difference is a clean
   // borrow flag.
   logic [17:0] rem_sh;
   logic [17:0] trial;
   logic        borrow;
   logic [16:0] rem_step;
   logic [15:0] sh_step;

   always_comb begin
      rem_sh   = {rem_q, sh_q[15]};
      trial    = rem_sh - {2'b00, dreg_q};
      borrow   = trial[17];
      rem_step = borrow ? rem_sh[16:0] : trial[16:0];
      sh_step  = {sh_q[14:0], ~borrow};
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sh_d    = sh_q;
      dreg_d  = dreg_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;

      case (state_q)
         S_RUN: begin
            rem_d = rem_step;
            sh_d  = sh_step;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               q_d     = sh_step;
               r_d     = rem_step[15:0];
               state_d = S_DONE;
            end
         end
         default: begin
            // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
            if (state_q == S_DONE)
               state_d = S_IDLE;
            if (bus.start) begin
               if (bus.D == 16'd0) begin
                  state_d = S_DONE;
                  dz_d    = 1'b1;
                  ovf_d   = 1'b0;
                  q_d     = 16'hFFFF;
                  r_d     = bus.N[15:0];
               end else if (bus.N[31:16] >= bus.D) begin
                  // Quotient would need more than 16 bits.
                  state_d = S_DONE;
                  dz_d    = 1'b0;
                  ovf_d   = 1'b1;
                  q_d     = 16'hFFFF;
                  r_d     = bus.N[15:0];
               end else begin
                  state_d = S_RUN;
                  rem_d   = {1'b0, bus.N[31:16]};
                  sh_d    = bus.N[15:0];
                  dreg_d  = bus.D;
                  cnt_d   = 4'd0;
                  dz_d    = 1'b0;
                  ovf_d   = 1'b0;
               end
            end
         end
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         sh_q    <= '0;
         dreg_q  <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         sh_q    <= sh_d;
         dreg_q  <= dreg_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.Q    = q_q;
   assign bus.R    = r_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dz   = dz_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: scoreboard bench for seq_div. The driver pushes the reference
// result of every issued operation; a monitor pops and compares on each
// done pulse. The driver separately checks latency and busy behaviour.
module tb_seq_div;

   typedef struct {
      logic [31:0] n;
      logic [15:0] d;
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   seq_div_if bus ();

   seq_div u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t scb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   dones  = 0;
   int   n_ops  = 0;

   // Reference model: plain integer division with the error rules.
   function automatic exp_t model(input logic [31:0] n, input logic [15:0] d);
      exp_t e;
      longint unsigned nn, dd;
      nn = longint'(n);
      dd = longint'(d);
      e.n = n;
      e.d = d;
      e.dz = 1'b0;
      e.ovf = 1'b0;
      if (dd == 0) begin
         e.dz = 1'b1;
         e.q  = 16'hFFFF;
         e.r  = n[15:0];
      end else if (nn / dd > 64'd65535) begin
         e.ovf = 1'b1;
         e.q   = 16'hFFFF;
         e.r   = n[15:0];
      end else begin
         e.q = 16'(nn / dd);
         e.r = 16'(nn % dd);
      end
      return e;
   endfunction

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.busy && bus.done) begin
            errors++;
            $display("FAIL busy_done_overlap busy=%0b done=%0b required not both 1",
                     bus.busy, bus.done);
         end
         if (bus.done) begin
            exp_t e;
            dones++;
            checks++;
            if (scb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done Q=%h R=%h with no operation outstanding",
                        bus.Q, bus.R);
            end else begin
               e = scb_q.pop_front();
               $display("op N=%h D=%h -> Q=%h R=%h dz=%0b ovf=%0b", e.n, e.d,
                        bus.Q, bus.R, bus.dz, bus.ovf);
               if ({bus.Q, bus.R, bus.dz, bus.ovf} !== {e.q, e.r, e.dz, e.ovf}) begin
                  errors++;
                  $display("FAIL result N=%h D=%h got Q=%h R=%h dz=%0b ovf=%0b required Q=%h R=%h dz=%0b ovf=%0b",
                           e.n, e.d, bus.Q, bus.R, bus.dz, bus.ovf, e.q, e.r, e.dz, e.ovf);
               end
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic start_op(input logic [31:0] n, input logic [15:0] d);
      scb_q.push_back(model(n, d));
      n_ops++;
      bus.start = 1'b1;
      bus.N     = n;
      bus.D     = d;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Waits (bounded) for done; k counts falling edges after the one following
   // the accept edge. Optionally pulses an ignored start at k == ignore_at.
   task automatic wait_done(input int exp_lat, input bit exp_busy, input int ignore_at);
      int k;
      bit got;
      bit busy_seen;
      k = 0;
      got = 1'b0;
      busy_seen = 1'b0;
      while (k <= 40) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         if (bus.busy) busy_seen = 1'b1;
         if (k == ignore_at) begin
            bus.start = 1'b1;
            bus.N     = 32'h0000_5555;
            bus.D     = 16'h0007;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      checks++;
      if (!got || k != exp_lat) begin
         errors++;
         $display("FAIL latency got=%0d seen=%0b required=%0d", k, got, exp_lat);
      end
      checks++;
      if (busy_seen != exp_busy) begin
         errors++;
         $display("FAIL busy_seen got=%0b required=%0b", busy_seen, exp_busy);
      end
   endtask

   task automatic run_op(input logic [31:0] n, input logic [15:0] d);
      exp_t e;
      e = model(n, d);
      start_op(n, d);
      wait_done((e.dz || e.ovf) ? 0 : 16, !(e.dz || e.ovf), -1);
   endtask

   initial begin
      int dones_before;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.N     = '0;
      bus.D     = '0;
      #12;
      checks++;
      if ({bus.Q, bus.R, bus.busy, bus.done, bus.dz, bus.ovf} !== 36'd0) begin
         errors++;
         $display("FAIL reset_state got Q=%h R=%h busy=%0b done=%0b dz=%0b ovf=%0b required all 0",
                  bus.Q, bus.R, bus.busy, bus.done, bus.dz, bus.ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed: basic op, then two back-to-back starts in DONE cycles.
      run_op(32'h001221CC, 16'h00FF);
      run_op(32'h000017A1, 16'h0002);
      run_op(32'h001221D1, 16'h00FF);
      @(negedge clk);

      // Error cases and the largest representable quotient.
      run_op(32'h12345678, 16'h0000);
      @(negedge clk);
      run_op(32'h00FF0000, 16'h00FF);
      @(negedge clk);
      run_op(32'hFFFE0001, 16'hFFFF);
      @(negedge clk);

      // Start while busy must be ignored.
      start_op(32'h001221CC, 16'h00FF);
      wait_done(16, 1'b1, 5);
      @(negedge clk);

      // Asynchronous reset mid-operation.
      start_op(32'h001221CC, 16'h00FF);
      repeat (8) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.Q, bus.R, bus.busy, bus.done, bus.dz, bus.ovf} !== 36'd0) begin
         errors++;
         $display("FAIL reset_midop got Q=%h R=%h busy=%0b done=%0b dz=%0b ovf=%0b required all 0",
                  bus.Q, bus.R, bus.busy, bus.done, bus.dz, bus.ovf);
      end
      scb_q.delete();
      n_ops--;
      dones_before = dones;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (dones != dones_before) begin
         errors++;
         $display("FAIL aborted_done got=%0d dones required=0", dones - dones_before);
      end
      run_op(32'h0000000A, 16'h0003);
      @(negedge clk);

      // Randomized operations with occasional back-to-back issue.
      for (int i = 0; i < 1000; i++) begin
         logic [31:0] n;
         logic [15:0] d;
         int mode;
         mode = $urandom_range(0, 9);
         d = 16'($urandom);
         n = $urandom;
         if (mode == 0) begin
            d = 16'h0000;
         end else if (mode >= 2) begin
            if (d == 16'h0000) d = 16'h0001;
            n[31:16] = 16'($urandom_range(0, int'(d) - 1));
         end
         run_op(n, d);
         if ($urandom_range(0, 1) == 0)
            repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      repeat (3) @(negedge clk);

      checks++;
      if (scb_q.size() != 0 || dones != n_ops) begin
         errors++;
         $display("FAIL completion_count dones=%0d pending=%0d required dones=%0d pending=0",
                  dones, scb_q.size(), n_ops);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
